sha256_msg_schedule: RTL and testbench

//  Producer side of the round-core W interface: accepts one 512-bit message block as 16 big-endian
//  32-bit words and emits the 64 schedule words W[0..63], one per round, on a valid/ready

---
 rtl/sha256_msg_schedule.sv | 102 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 16-word block, then streams W[0..ROUNDS-1] on a
// valid/ready handshake, generating W[t+16] from a 16-word sliding window.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [31:0]      blk_word,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_data,
    output logic [CNT_W-1:0] w_round,
    output logic             w_last,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       count;
    logic [CNT_W-1:0] t;
    logic [31:0]      win [16];

    logic             blk_hs;
    logic             w_hs;
    logic             last_round;
    logic [31:0]      w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign blk_ready  = (state == IDLE) || (state == LOAD);
    assign w_valid    = (state == RUN);
    assign blk_hs     = blk_valid && blk_ready;
    assign w_hs       = w_valid && w_ready;
    assign last_round = (t == CNT_W'(ROUNDS - 1));
    assign w_next     = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    assign w_data  = w_valid ? win[0] : 32'h0;
    assign w_round = t;
    assign w_last  = w_valid && last_round;
    assign busy    = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so the window shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
            t     <= '0;
            // NOTE: the window is a register file, not RAM, so clearing it on reset is cheap and gives w_data a defined value.
            for (int i = 0; i < 16; i++) win[i] <= 32'h0;
        end else if (flush) begin
            // Window deliberately left intact; the next load overwrites it slot by slot.
            state <= IDLE;
            count <= 4'd0;
            t     <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (blk_hs) begin
                        for (int i = 0; i < 16; i++) begin
                            if (count == 4'(i)) win[i] <= blk_word;
                        end
                        count <= count + 4'd1;
                        t     <= '0;
                        state <= (count == 4'd15) ? RUN : LOAD;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= w_next;
                        if (last_round) begin
                            state <= IDLE;
                            t     <= '0;
                            count <= 4'd0;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: a scoreboard of golden W values is filled when the
// 16th block word is accepted and drained as the DUT hands out schedule words.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_round;
    logic        w_last;
    logic        busy;

    sha256_msg_schedule #(.ROUNDS(64), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_word  (blk_word),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_round   (w_round),
        .w_last    (w_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  round;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] ld_words [16];
    logic [31:0] cap [64];
    logic [31:0] blk_a [16];
    logic [31:0] blk_b [16];
    int          load_cnt = 0;
    int          errors   = 0;
    int          checks   = 0;
    int          cycles   = 0;
    bit          chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    task automatic push_gold();
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = ld_words[i];
        for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) sb.push_back('{data: w[i], round: 6'(i)});
    endtask

    // One clock: check outputs against the model, update the model from this cycle's handshakes.
    task automatic tick();
        if (chk_en) begin
            check("w_valid", 32'(w_valid), 32'(sb.size() != 0));
            check("blk_ready", 32'(blk_ready), 32'(sb.size() == 0));
            check("busy", 32'(busy), 32'((sb.size() != 0) || (load_cnt != 0)));
            check("w_last", 32'(w_last), 32'(sb.size() == 1));
            if (sb.size() != 0) begin
                check("w_data", w_data, sb[0].data);
                check("w_round", 32'(w_round), 32'(sb[0].round));
            end
        end
        if (rst || flush) begin
            sb.delete();
            load_cnt = 0;
        end else begin
            if (w_valid && w_ready && sb.size() != 0) begin
                cap[w_round] = w_data;
                void'(sb.pop_front());
            end
            if (blk_valid && blk_ready) begin
                ld_words[load_cnt] = blk_word;
                load_cnt++;
                if (load_cnt == 16) begin
                    push_gold();
                    load_cnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL cycle_budget observed=%0d expected<=50000", cycles);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic load_words(input logic [31:0] b [16], input int n, input bit gaps);
        bit got;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                blk_valid = 1'b0;
                tick();
            end
            blk_valid = 1'b1;
            blk_word  = b[k];
            got = 1'b0;
            for (int j = 0; j < 20 && !got; j++) begin
                got = blk_ready;
                tick();
            end
            check("load_accept", 32'(got), 32'd1);
        end
        blk_valid = 1'b0;
    endtask

    task automatic run_to_round(input int r);
        w_ready = 1'b1;
        for (int i = 0; i < 200 && !(w_valid === 1'b1 && w_round === 6'(r)); i++) tick();
        check("reach_round", 32'(w_round), 32'(r));
    endtask

    task automatic drain();
        w_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 64; i++) cap[i] = 32'h0;
    endtask

    task automatic check_abc();
        check("abc_W16", cap[16], 32'h61626380);
        check("abc_W17", cap[17], 32'h000F0000);
        check("abc_W18", cap[18], 32'h7DA86405);
        check("abc_W63", cap[63], 32'h12B1EDEB);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) blk_a[i] = 32'h0;
        blk_a[0]  = 32'h61626380;
        blk_a[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) blk_b[i] = $urandom;

        rst = 1'b1; flush = 1'b0; blk_valid = 1'b0; blk_word = 32'h0; w_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        check("rst_w_data", w_data, 32'h0);
        check("rst_w_round", 32'(w_round), 32'd0);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        tick();

        // T1: "abc" block, w_ready held high
        clear_cap();
        w_ready = 1'b1;
        load_words(blk_a, 16, 1'b0);
        drain();
        check_abc();
        tick();

        // T2: 3-cycle stall at t=20
        clear_cap();
        w_ready = 1'b1;
        load_words(blk_a, 16, 1'b0);
        run_to_round(20);
        w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_round", 32'(w_round), 32'd20);
            tick();
        end
        drain();
        check_abc();

        // T3: loader gaps every other cycle
        clear_cap();
        load_words(blk_a, 16, 1'b1);
        drain();
        check_abc();

        // T4: reset mid-run at t=30, then reload
        load_words(blk_a, 16, 1'b0);
        run_to_round(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_round", 32'(w_round), 32'd0);
        check("rst_mid_valid", 32'(w_valid), 32'd0);
        tick();
        clear_cap();
        load_words(blk_a, 16, 1'b0);
        drain();
        check_abc();

        // T5a: flush coincident with a W handshake at t=10
        load_words(blk_a, 16, 1'b0);
        run_to_round(10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_round", 32'(w_round), 32'd0);
        check("flush_valid", 32'(w_valid), 32'd0);
        tick();
        tick();

        // T5b: flush in LOAD at count=7 drops the word; next load restarts at slot 0
        load_words(blk_a, 7, 1'b0);
        blk_valid = 1'b1;
        blk_word  = blk_a[7];
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        blk_valid = 1'b0;
        check("flush_load_busy", 32'(busy), 32'd0);
        tick();
        load_words(blk_b, 16, 1'b0);
        drain();

        // T6: second block presented from the last W handshake onward
        load_words(blk_a, 16, 1'b0);
        w_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 1; i++) tick();
        check("b2b_last_pending", 32'(sb.size()), 32'd1);
        blk_valid = 1'b1;
        blk_word  = blk_b[0];
        tick();
        check("b2b_ready_next", 32'(blk_ready), 32'd1);
        load_words(blk_b, 16, 1'b0);
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
